// File: rtl/msoc_copy_pkg.sv
// Shared definitions for the word-copy Avalon-MM master.
//   copy_state_e    : FSM state encoding (IDLE=0 .. FINISH=4)
//   WORD_BYTES      : byte stride between consecutive 32-bit words
//   BE_ALL/BE_NONE  : byteenable values for active / idle bus cycles
//   addr_misaligned : true when a byte address is not word aligned
package msoc_copy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FINISH  = 3'd4
    } copy_state_e;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  BE_ALL     = 4'hF;
    localparam logic [3:0]  BE_NONE    = 4'h0;

    function automatic logic addr_misaligned(input logic [1:0] lsbs);
        return (lsbs != 2'b00);
    endfunction

endpackage

// File: rtl/msoc_word_copy_master.sv
// Avalon-MM master that copies cmd_len 32-bit words from cmd_src to cmd_dst,
// one non-pipelined word at a time, in ascending address order.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   cmd_start/src/dst/len       : copy command, accepted only while idle
//   busy, done, err             : status (done is a one-cycle pulse, err sticky)
//   avm_*                       : Avalon-MM master port (byte addressed)
module msoc_word_copy_master
    import msoc_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    copy_state_e       state_r;
    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [LEN_W-1:0]  remaining_r;

    // Copy FSM with all bus and status outputs registered.
    // avm_writedata doubles as the word buffer between read and write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            src_ptr_r      <= '0;
            dst_ptr_r      <= '0;
            remaining_r    <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= BE_NONE;
            avm_writedata  <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_start) begin
                        src_ptr_r   <= cmd_src;
                        dst_ptr_r   <= cmd_dst;
                        remaining_r <= cmd_len;
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        if (addr_misaligned(cmd_src[1:0]) || addr_misaligned(cmd_dst[1:0])) begin
                            err     <= 1'b1;
                            state_r <= FINISH;
                        end else if (cmd_len == '0) begin
                            state_r <= FINISH;
                        end else begin
                            // First read is issued straight from IDLE.
                            state_r        <= RD_REQ;
                            avm_read       <= 1'b1;
                            avm_address    <= cmd_src;
                            avm_byteenable <= BE_ALL;
                        end
                    end
                end
                RD_REQ: begin
                    if (!avm_read) begin
                        // Entered from a completed write: one idle bus cycle
                        // before the next read is raised.
                        avm_read       <= 1'b1;
                        avm_address    <= src_ptr_r;
                        avm_byteenable <= BE_ALL;
                    end else if (!avm_waitrequest) begin
                        avm_read       <= 1'b0;
                        avm_byteenable <= BE_NONE;
                        if (avm_readdatavalid) begin
                            // Zero-latency slave: data came with acceptance.
                            avm_writedata  <= avm_readdata;
                            avm_write      <= 1'b1;
                            avm_address    <= dst_ptr_r;
                            avm_byteenable <= BE_ALL;
                            state_r        <= WR_REQ;
                        end else begin
                            state_r <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        avm_writedata  <= avm_readdata;
                        avm_write      <= 1'b1;
                        avm_address    <= dst_ptr_r;
                        avm_byteenable <= BE_ALL;
                        state_r        <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_write      <= 1'b0;
                        avm_byteenable <= BE_NONE;
                        src_ptr_r      <= src_ptr_r + ADDR_W'(WORD_BYTES);
                        dst_ptr_r      <= dst_ptr_r + ADDR_W'(WORD_BYTES);
                        remaining_r    <= remaining_r - LEN_W'(1);
                        if (remaining_r == LEN_W'(1)) begin
                            state_r <= FINISH;
                        end else begin
                            state_r <= RD_REQ;
                        end
                    end
                end
                FINISH: begin
                    // busy drops together with the done pulse.
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r        <= IDLE;
                    busy           <= 1'b0;
                    avm_read       <= 1'b0;
                    avm_write      <= 1'b0;
                    avm_byteenable <= BE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msoc_word_copy_master.sv
module tb_msoc_word_copy_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_src = 32'h0;
    logic [31:0] cmd_dst = 32'h0;
    logic [15:0] cmd_len = 16'h0;
    logic        busy, done, err;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;

    int total = 0;
    int bad = 0;

    // slave model state
    logic [31:0] mem [0:16383];
    int          stall_cnt = 0;
    bit          stall_en = 1'b0;
    int          rd_acc = 0;
    int          wr_acc = 0;
    int          req_cycles = 0;
    bit          pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    // monitor state
    bit          hold_v = 1'b0;
    logic [31:0] hold_addr = 32'h0;
    logic [1:0]  hold_rw = 2'b00;
    logic [31:0] hold_wd = 32'h0;

    msoc_word_copy_master #(.ADDR_W(32), .LEN_W(16), .DATA_W(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cmd_start         (cmd_start),
        .cmd_src           (cmd_src),
        .cmd_dst           (cmd_dst),
        .cmd_len           (cmd_len),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_byteenable    (avm_byteenable),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Avalon slave memory: read latency 1, optional random stalls of 0-5 cycles.
    assign avm_waitrequest = (avm_read || avm_write) && stall_en && (stall_cnt != 0);

    always @(posedge clk) begin
        avm_readdatavalid <= 1'b0;
        if (pl_en) mem[pl_addr[15:2]] <= pl_data;
        if ((avm_read || avm_write) && !avm_waitrequest) begin
            if (avm_write) begin
                mem[avm_address[15:2]] <= avm_writedata;
                wr_acc <= wr_acc + 1;
            end else begin
                avm_readdata      <= mem[avm_address[15:2]];
                avm_readdatavalid <= 1'b1;
                rd_acc <= rd_acc + 1;
            end
            stall_cnt <= int'($urandom_range(5, 0));
        end else if ((avm_read || avm_write) && stall_cnt != 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    // Bus protocol monitor: byteenable, read/write exclusion, hold during stall.
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_read || avm_write) begin
                req_cycles <= req_cycles + 1;
                check_eq("be_active", {28'h0, avm_byteenable}, 32'hF);
                check_eq("rw_excl", {31'h0, avm_read & avm_write}, 32'h0);
            end else begin
                check_eq("be_idle", {28'h0, avm_byteenable}, 32'h0);
            end
            if (hold_v) begin
                check_eq("hold_addr", avm_address, hold_addr);
                check_eq("hold_rw", {30'h0, avm_read, avm_write}, {30'h0, hold_rw});
                if (hold_rw[0]) check_eq("hold_wdata", avm_writedata, hold_wd);
            end
            hold_v    <= (avm_read || avm_write) && avm_waitrequest;
            hold_addr <= avm_address;
            hold_rw   <= {avm_read, avm_write};
            hold_wd   <= avm_writedata;
        end else begin
            hold_v <= 1'b0;
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_ctl"}, {27'h0, busy, done, err, avm_read, avm_write}, 32'h0);
        check_eq({tag, "_addr"}, avm_address, 32'h0);
        check_eq({tag, "_wdata"}, avm_writedata, 32'h0);
        check_eq({tag, "_be"}, {28'h0, avm_byteenable}, 32'h0);
    endtask

    // Issue one command; latency counted in cycles with the start cycle as 0.
    // inject_k / reset_k: edge index after acceptance at which a second start
    // is driven, or at which reset is asserted (0 = never).
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                            input int exp_lat, input int inject_k, input int reset_k);
        int  k;
        bit  seen;
        bit  aborted;
        @(negedge clk);
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        check_eq("busy_after_start", {31'h0, busy}, 32'h1);
        k = 0;
        seen = 1'b0;
        aborted = 1'b0;
        while (!seen && !aborted && k < 3000) begin
            @(posedge clk);
            k++;
            #1;
            cmd_start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (k == inject_k) begin
                cmd_start = 1'b1;
                cmd_src = 32'h0000_0300;
                cmd_dst = 32'h0000_6000;
                cmd_len = 16'd3;
            end else if (k == reset_k) begin
                check_eq("write_before_reset", {31'h0, avm_write}, 32'h1);
                reset_n = 1'b0;
                #1;
                check_outputs_zero("reset_mid");
                aborted = 1'b1;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        if (!aborted) begin
            if (!seen) begin
                check_eq("done_timeout", {31'h0, done}, 32'h1);
            end else begin
                check_eq("busy_in_done", {31'h0, busy}, 32'h0);
                if (exp_lat > 0) check_eq("latency", k + 1, exp_lat);
                @(posedge clk);
                #1;
                check_eq("done_single", {31'h0, done}, 32'h0);
            end
        end
    endtask

    logic [31:0] basic_words [0:3] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] stall_words [0:7] = '{32'hA5A50000, 32'h5A5A0001, 32'h0F0F0002, 32'hF0F00003,
                                       32'h12345678, 32'h9ABCDEF0, 32'hCAFEBABE, 32'h0BADF00D};
    logic [31:0] rst_words   [0:5] = '{32'h60000001, 32'h60000002, 32'h60000003,
                                       32'h60000004, 32'h60000005, 32'h60000006};

    initial begin
        int rd0, wr0, rq0;

        // Reset state
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic copy, zero-wait slave
        for (int i = 0; i < 4; i++) begin
            preload(32'h0000_0000 + 32'(i * 4), basic_words[i]);
            preload(32'h0000_4000 + 32'(i * 4), 32'h0);
        end
        rd0 = rd_acc;
        wr0 = wr_acc;
        run_copy(32'h0000_0000, 32'h0000_4000, 16'd4, 17, 0, 0);
        for (int i = 0; i < 4; i++) check_eq("basic_data", mem[(32'h4000 >> 2) + i], basic_words[i]);
        check_eq("basic_reads", rd_acc - rd0, 4);
        check_eq("basic_writes", wr_acc - wr0, 4);
        check_eq("basic_err", {31'h0, err}, 32'h0);

        // Random stalls, len=8
        for (int i = 0; i < 8; i++) begin
            preload(32'h0000_1000 + 32'(i * 4), stall_words[i]);
            preload(32'h0000_4800 + 32'(i * 4), 32'h0);
        end
        stall_en = 1'b1;
        run_copy(32'h0000_1000, 32'h0000_4800, 16'd8, 0, 0, 0);
        stall_en = 1'b0;
        for (int i = 0; i < 8; i++) check_eq("stall_data", mem[(32'h4800 >> 2) + i], stall_words[i]);

        // Misaligned source
        rq0 = req_cycles;
        run_copy(32'h0000_0002, 32'h0000_4000, 16'd4, 2, 0, 0);
        check_eq("misaligned_err", {31'h0, err}, 32'h1);
        check_eq("misaligned_no_bus", req_cycles - rq0, 0);

        // Zero length clears err
        rq0 = req_cycles;
        run_copy(32'h0000_0000, 32'h0000_4000, 16'd0, 2, 0, 0);
        check_eq("zero_len_err", {31'h0, err}, 32'h0);
        check_eq("zero_len_no_bus", req_cycles - rq0, 0);

        // Start while busy is ignored
        for (int i = 0; i < 3; i++) begin
            preload(32'h0000_0100 + 32'(i * 4), 32'hB0B0_0000 + 32'(i));
            preload(32'h0000_5000 + 32'(i * 4), 32'h0);
            preload(32'h0000_0300 + 32'(i * 4), 32'hC1C1_0000 + 32'(i));
            preload(32'h0000_6000 + 32'(i * 4), 32'hDEAD_0000 + 32'(i));
        end
        wr0 = wr_acc;
        run_copy(32'h0000_0100, 32'h0000_5000, 16'd3, 13, 5, 0);
        check_eq("busy_start_d0", mem[32'h5000 >> 2], 32'hB0B00000);
        check_eq("busy_start_d1", mem[(32'h5000 >> 2) + 1], 32'hB0B00001);
        check_eq("busy_start_d2", mem[(32'h5000 >> 2) + 2], 32'hB0B00002);
        check_eq("busy_start_untouched", mem[(32'h6000 >> 2) + 1], 32'hDEAD0001);
        check_eq("busy_start_writes", wr_acc - wr0, 3);

        // Reset during WR_REQ of word 3 of 6
        for (int i = 0; i < 6; i++) begin
            preload(32'h0000_2000 + 32'(i * 4), rst_words[i]);
            preload(32'h0000_7000 + 32'(i * 4), 32'hFFFFFFFF);
        end
        run_copy(32'h0000_2000, 32'h0000_7000, 16'd6, 0, 0, 10);
        check_eq("reset_partial_w0", mem[32'h7000 >> 2], rst_words[0]);
        check_eq("reset_partial_w1", mem[(32'h7000 >> 2) + 1], rst_words[1]);
        check_eq("reset_partial_w2", mem[(32'h7000 >> 2) + 2], 32'hFFFFFFFF);
        check_outputs_zero("after_release");
        preload(32'h0000_7800, 32'h0);
        preload(32'h0000_7804, 32'h0);
        run_copy(32'h0000_2000, 32'h0000_7800, 16'd2, 9, 0, 0);
        check_eq("post_reset_w0", mem[32'h7800 >> 2], rst_words[0]);
        check_eq("post_reset_w1", mem[(32'h7800 >> 2) + 1], rst_words[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
